// File: rtl/cpstr_mux_tx.sv
// Round-robin multiplexer that merges NUM_STREAMS byte streams into one escaped byte stream.
// A header {ESC_CHAR, idx} marks each change of the active stream, and literal ESC_CHAR data is sent twice.
module cpstr_mux_tx #(
    parameter int          NUM_STREAMS = 4,
    parameter int          BURST_W     = 8,
    parameter logic [7:0]  ESC_CHAR    = 8'hFF
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [8*NUM_STREAMS-1:0]         i_data,
    input  logic [NUM_STREAMS-1:0]           i_valid,
    output logic [NUM_STREAMS-1:0]           o_ready,
    input  logic [NUM_STREAMS-1:0]           i_en,
    input  logic [BURST_W*NUM_STREAMS-1:0]   i_burst_len,
    output logic [7:0]                       o_data,
    output logic                             o_valid,
    input  logic                             i_ready,
    input  logic                             i_send_stridx,
    output logic [$clog2(NUM_STREAMS)-1:0]   o_cur_idx
);

    localparam int IDX_W = $clog2(NUM_STREAMS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HDR_ESC = 3'd1;
    localparam logic [2:0] S_HDR_IDX = 3'd2;
    localparam logic [2:0] S_DATA    = 3'd3;
    localparam logic [2:0] S_LIT     = 3'd4;

    logic [2:0]             state;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       rr;
    logic [BURST_W-1:0]     burst_rem;
    logic [BURST_W-1:0]     burst_quota;
    logic                   cfrm_valid;
    logic                   resend_pend;
    logic                   lit_to_idle;

    logic [NUM_STREAMS-1:0] req;
    logic [NUM_STREAMS-1:0] grant_oh;
    logic                   has_comp;
    logic                   out_free;
    logic                   ready_g;
    logic                   accept;
    logic                   expiry;
    logic                   leave_idle;
    logic [7:0]             cur_byte;
    logic [IDX_W-1:0]       pick;
    logic                   pick_found;

    assign req      = i_valid & i_en;
    assign out_free = !o_valid || i_ready;
    assign grant_oh = NUM_STREAMS'(1) << grant;
    assign has_comp = |(req & ~grant_oh);
    assign cur_byte = i_data[{grant, 3'b000} +: 8];

    // Byte acceptance is held off while a header resend is waiting so the header is not split.
    assign ready_g    = (state == S_DATA) && out_free && !resend_pend;
    assign o_ready    = ready_g ? grant_oh : '0;
    assign accept     = ready_g && i_valid[grant];
    assign expiry     = accept && (burst_rem == BURST_W'(1));
    assign leave_idle = (expiry && has_comp) || !i_en[grant] ||
                        (!accept && !i_valid[grant] && has_comp);

    // Round-robin search begins just after the last granted stream and wraps.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= NUM_STREAMS; i++) begin
            if (!pick_found && req[(int'(rr) + i) % NUM_STREAMS]) begin
                pick       = IDX_W'((int'(rr) + i) % NUM_STREAMS);
                pick_found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            grant       <= '0;
            rr          <= IDX_W'(NUM_STREAMS - 1);
            burst_rem   <= '0;
            burst_quota <= '0;
            cfrm_valid  <= 1'b0;
            resend_pend <= 1'b0;
            lit_to_idle <= 1'b0;
            o_cur_idx   <= '0;
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
        end else begin
            if (i_send_stridx) begin
                resend_pend <= 1'b1;
            end
            if (out_free) begin
                o_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant       <= pick;
                        rr          <= pick;
                        burst_rem   <= i_burst_len[int'(pick)*BURST_W +: BURST_W];
                        burst_quota <= i_burst_len[int'(pick)*BURST_W +: BURST_W];
                        if (pick == o_cur_idx && cfrm_valid && !resend_pend) begin
                            state <= S_DATA;
                        end else begin
                            state <= S_HDR_ESC;
                        end
                    end
                end
                S_HDR_ESC: begin
                    if (out_free) begin
                        o_valid <= 1'b1;
                        o_data  <= ESC_CHAR;
                        state   <= S_HDR_IDX;
                    end
                end
                S_HDR_IDX: begin
                    if (out_free) begin
                        o_valid     <= 1'b1;
                        o_data      <= 8'(grant);
                        o_cur_idx   <= grant;
                        cfrm_valid  <= 1'b1;
                        resend_pend <= 1'b0;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        o_valid <= 1'b1;
                        o_data  <= cur_byte;
                        // A zero quota means unlimited, so the counter is left alone.
                        if (burst_rem != '0) begin
                            burst_rem <= (expiry && !has_comp) ? burst_quota
                                                               : burst_rem - BURST_W'(1);
                        end
                        if (cur_byte == ESC_CHAR) begin
                            state       <= S_LIT;
                            lit_to_idle <= leave_idle;
                        end else if (leave_idle) begin
                            state <= S_IDLE;
                        end
                    end else if (leave_idle) begin
                        state <= S_IDLE;
                    end else if (resend_pend) begin
                        state <= S_HDR_ESC;
                    end
                end
                S_LIT: begin
                    if (out_free) begin
                        o_valid <= 1'b1;
                        o_data  <= ESC_CHAR;
                        if (lit_to_idle) begin
                            state <= S_IDLE;
                        end else if (resend_pend) begin
                            state <= S_HDR_ESC;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
